// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sdiv response path.
package sdiv_pkg;

  localparam int SDIV_DEF_W = 32;

  // Default-width response word. Modules with non-default widths declare a local equivalent.
  typedef struct packed {
    logic signed [SDIV_DEF_W-1:0] q;
    logic signed [SDIV_DEF_W-1:0] r;
  } sdiv_rsp_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdiv_rsp_buf_if.sv
// Valid/ready stream carrying one signed quotient/remainder pair per beat.
interface sdiv_rsp_buf_if
  import sdiv_pkg::*;
#(
  parameter int M = SDIV_DEF_W,
  parameter int N = SDIV_DEF_W
);
  logic                valid;
  logic                ready;
  logic signed [M-1:0] q;
  logic signed [N-1:0] r;

  modport master (output valid, q, r, input ready);
  modport slave  (input valid, q, r, output ready);
endinterface

// File: rtl/sdiv_fifo.sv
// Register-array synchronous FIFO; full/empty come from the occupancy count.
module sdiv_fifo
  import sdiv_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              wdata,
  input  logic                      pop,
  output logic [W-1:0]              rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_e, pop_e;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_e  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push at full is still taken then.
  assign push_e = push & (~full | pop_e);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_e) wr_ptr <= wr_ptr + AW'(1);
      if (pop_e)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_e) - CW'(pop_e);
    end
  end

  always_ff @(posedge clk) begin
    if (push_e) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sdiv_rsp_buf.sv
// Response buffer for the no-backpressure signed divider: credit accounting, FIFO, sticky error.
// Optional SDIV_RSP_BUF_STATS_EN adds pop and stall counters.
module sdiv_rsp_buf
  import sdiv_pkg::*;
#(
  parameter int M     = SDIV_DEF_W,
  parameter int N     = SDIV_DEF_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  output logic                     credit_ok,
  input  logic                     div_vld,
  input  logic signed [M-1:0]      div_q,
  input  logic signed [N-1:0]      div_r,
  sdiv_rsp_buf_if.master           out,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     err
`ifdef SDIV_RSP_BUF_STATS_EN
  ,
  output logic [31:0]              stat_results,
  output logic [31:0]              stat_stalls
`endif
);
  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic signed [M-1:0] q;
    logic signed [N-1:0] r;
  } rsp_t;

  rsp_t          wr_word, rd_word;
  logic [CW-1:0] inflight;
  logic [CW:0]   occupancy;
  logic          full, empty;
  logic          iss_ok, accept, stale, drop, pop;

  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);
  assign iss_ok    = issue & credit_ok;
  assign accept    = div_vld & (inflight != '0);
  assign stale     = div_vld & (inflight == '0);
  assign pop       = out.valid & out.ready;
  assign drop      = accept & full & ~pop;
  assign wr_word   = '{q: div_q, r: div_r};

  sdiv_fifo #(.W($bits(rsp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (wr_word),
    .pop   (out.ready),
    .rdata (rd_word),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out.valid = ~empty;
  assign out.q     = rd_word.q;
  assign out.r     = rd_word.r;

  // Results owed by the divider; an accepted result retires one even if it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      unique case ({iss_ok, accept})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if ((issue & ~credit_ok) | stale | drop) err <= 1'b1;
    end
  end

`ifdef SDIV_RSP_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_results <= '0;
      stat_stalls  <= '0;
    end else begin
      if (pop)                    stat_results <= stat_results + 32'd1;
      if (out.valid & ~out.ready) stat_stalls  <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdiv_rsp_buf.sv
// Scoreboard bench for sdiv_rsp_buf: queue-based reference model plus a stand-in divider delay line.
module tb_sdiv_rsp_buf;
  localparam int M     = 32;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = M;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_n, issue, div_vld, credit_ok, err;
  logic signed [M-1:0] div_q;
  logic signed [N-1:0] div_r;
  logic [CW-1:0]       count;
`ifdef SDIV_RSP_BUF_STATS_EN
  logic [31:0]         stat_results, stat_stalls;
`endif

  always #5 clk = ~clk;

  sdiv_rsp_buf_if #(.M(M), .N(N)) bus ();

  sdiv_rsp_buf #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .credit_ok (credit_ok),
    .div_vld   (div_vld),
    .div_q     (div_q),
    .div_r     (div_r),
    .out       (bus.master),
    .count     (count),
    .err       (err)
`ifdef SDIV_RSP_BUF_STATS_EN
    ,
    .stat_results (stat_results),
    .stat_stalls  (stat_stalls)
`endif
  );

  typedef struct {
    int                  due;
    logic signed [M-1:0] q;
    logic signed [N-1:0] r;
  } pend_t;

  typedef struct {
    logic signed [M-1:0] q;
    logic signed [N-1:0] r;
  } rsp_t;

  pend_t       pend[$];
  rsp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_count, m_infl;
  bit          m_err;
  logic [31:0] m_res, m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer side: every accepted beat must match the oldest expected result.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n === 1'b1 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=beat required=none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("head_q", 64'(bus.q), 64'(e.q));
        check("head_r", 64'(bus.r), 64'(e.r));
      end
    end
  end

  // One clock of stimulus: check state, drive inputs, advance the model.
  task automatic step(input bit iss, input bit rdy,
                      input logic signed [M-1:0] iq, input logic signed [N-1:0] ir,
                      input bit stale_vld, input logic signed [M-1:0] sq);
    bit credit, pop, vld, acc;
    logic signed [M-1:0] q;
    logic signed [N-1:0] r;
    credit = (m_count + m_infl) < DEPTH;
    check("credit_ok", 64'(credit_ok), 64'(credit));
    check("count",     64'(count),     64'(m_count));
    check("out_valid", 64'(bus.valid), 64'(m_count > 0));
    check("err",       64'(err),       64'(m_err));
`ifdef SDIV_RSP_BUF_STATS_EN
    check("stat_results", 64'(stat_results), 64'(m_res));
    check("stat_stalls",  64'(stat_stalls),  64'(m_stall));
`endif
    vld = 1'b0; q = '0; r = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      vld = 1'b1; q = pend[0].q; r = pend[0].r;
      void'(pend.pop_front());
    end else if (stale_vld) begin
      vld = 1'b1; q = sq;
    end
    issue = iss; bus.ready = rdy; div_vld = vld; div_q = q; div_r = r;

    pop = (m_count > 0) && rdy;
    acc = 1'b0;
    if (iss && !credit) m_err = 1'b1;
    if (vld) begin
      if (m_infl == 0) m_err = 1'b1;
      else begin
        acc = 1'b1;
        if (m_count == DEPTH && !pop) m_err = 1'b1;
        else begin
          sb.push_back('{q, r});
          m_count++;
        end
      end
    end
    if (pop) begin
      m_count--;
      m_res++;
    end
    if (m_count > 0 && !rdy && !(vld && acc && m_count == 1 && !pop && sb.size() > 0 && 0)) ;
    if (iss && credit) begin
      m_infl++;
      pend.push_back('{cyc + LAT, iq, ir});
    end
    if (acc) m_infl--;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stall accounting uses occupancy before this cycle's push, so it is tracked separately.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.valid === 1'b1 && bus.ready === 1'b0) m_stall <= m_stall + 32'd1;
  end

  task automatic idle(input bit rdy);
    step(1'b0, rdy, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; issue = 1'b0; div_vld = 1'b0; div_q = '0; div_r = '0; bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_count = 0; m_infl = 0; m_err = 1'b0; m_res = '0; m_stall = '0;
    pend.delete();
    sb.delete();
  endtask

  initial begin
    int prob;
    bit credit;
    do_reset();
    repeat (3) idle(1'b0);

    // Four issues with a stalled consumer fill the buffer; a fifth is a credit violation.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom, $urandom, 1'b0, '0);
    step(1'b1, 1'b0, 32'sd99, 32'sd99, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);
    repeat (6) idle(1'b1);
    do_reset();

    // Back-to-back streaming with a ready consumer.
    step(1'b1, 1'b1, 32'sd7, 32'sd1, 1'b0, '0);
    step(1'b1, 1'b1, -32'sd3, 32'sd2, 1'b0, '0);
    repeat (LAT + 4) idle(1'b1);

    // Stale result with nothing in flight.
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'sh55);
    repeat (3) idle(1'b1);
    do_reset();
    idle(1'b0);

    // Randomized traffic with varying consumer pressure.
    for (int blk = 0; blk < 6; blk++) begin
      prob = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 5 : 9);
      for (int i = 0; i < 400; i++) begin
        credit = (m_count + m_infl) < DEPTH;
        step(credit && ($urandom_range(0, 3) != 0), $urandom_range(0, 9) < prob,
             $urandom, $urandom, 1'b0, '0);
      end
    end
    for (int i = 0; i < LAT + 8; i++) idle(1'b1);

    // Three results, then a consumer that stalls before draining.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, $urandom, 1'b0, '0);
    repeat (LAT + 4) idle(1'b0);
    repeat (4) idle(1'b1);
    do_reset();
    idle(1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
